// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// default timing constants (10 ms stable time at the 16 MHz board clock).
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } db_state_t;

  localparam int STABLE_CYCLES_DEFAULT = 160_000;
  localparam int CNT_W_DEFAULT         = 18;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset, used on
// every raw pin entering the clock domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_reg;
  logic s0_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s0_reg <= 1'b0;
    end else begin
      s1_reg <= d;
      s0_reg <= s1_reg;
    end
  end

  assign q = s0_reg;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw button pin: synchronise, require STABLE_CYCLES of a steady
// new value, then emit a clean level plus rise/fall pulses. Define
// BTN_TOGGLE_EN to add a latched toggle output that flips on every press.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic db_toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  db_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             s0;
  logic             rise_now;
  logic             fall_now;

  sync_2ff u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s0)
  );

  // Acceptance conditions, shared with the optional toggle flop so it flips
  // on the same edge the rise pulse is registered.
  assign rise_now = (state_reg == ST_WAIT_HI) && s0 && (cnt_reg == CNT_LAST);
  assign fall_now = (state_reg == ST_WAIT_LO) && !s0 && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        ST_LOW: begin
          if (s0) begin
            state_reg <= ST_WAIT_HI;
            cnt_reg   <= '0;
          end
        end
        ST_WAIT_HI: begin
          if (!s0) begin
            state_reg <= ST_LOW;
          end else if (rise_now) begin
            state_reg <= ST_HIGH;
            level_reg <= 1'b1;
            rise_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!s0) begin
            state_reg <= ST_WAIT_LO;
            cnt_reg   <= '0;
          end
        end
        ST_WAIT_LO: begin
          if (s0) begin
            state_reg <= ST_HIGH;
          end else if (fall_now) begin
            state_reg <= ST_LOW;
            level_reg <= 1'b0;
            fall_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_LOW;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign db_level = level_reg;
  assign db_rise  = rise_reg;
  assign db_fall  = fall_reg;

`ifdef BTN_TOGGLE_EN
  logic toggle_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_reg <= 1'b0;
    end else if (rise_now) begin
      toggle_reg <= ~toggle_reg;
    end
  end

  assign db_toggle = toggle_reg;
`else
  assign db_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=8: expected pulses are
// queued when the button is driven and matched against observed pulses.
module tb_button_debouncer;

  localparam int SC = 8;
  localparam int CW = 4;
`ifdef BTN_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic db_level, db_rise, db_fall, db_toggle;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit tog_model = 1'b0;

  typedef struct {
    bit is_rise;
    int at;
    bit tog;
  } ev_t;
  ev_t exp_q[$];

  button_debouncer #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .db_level  (db_level),
    .db_rise   (db_rise),
    .db_fall   (db_fall),
    .db_toggle (db_toggle)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk1(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chki(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Edge 0 is the first posedge after the drive; acceptance lands at edge SC+2.
  task automatic push_ev(bit r);
    ev_t e;
    if (r && TOG_EN) tog_model = ~tog_model;
    e.is_rise = r;
    e.at      = cyc + SC + 3;
    e.tog     = tog_model;
    exp_q.push_back(e);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: every observed pulse must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (db_rise || db_fall) begin
        chk1("rise_fall_exclusive", db_rise & db_fall, 1'b0);
        if (exp_q.size() == 0) begin
          chki("unexpected_pulse_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          chk1("pulse_kind", db_rise, e.is_rise);
          chki("pulse_cycle", cyc, e.at);
          chk1("pulse_toggle", db_toggle, e.tog);
          $display("cycle %0d: %s level=%b toggle=%b", cyc,
                   db_rise ? "rise" : "fall", db_level, db_toggle);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn_raw = 1'b0;
    cycles(3);
    chk1("reset_level", db_level, 1'b0);
    chk1("reset_rise", db_rise, 1'b0);
    chk1("reset_fall", db_fall, 1'b0);
    chk1("reset_toggle", db_toggle, 1'b0);
    reset = 1'b0;
    cycles(4);

    // Reset in the middle of WAIT_HI: count must start over after release
    btn_raw = 1'b1;
    cycles(6);
    #2 reset = 1'b1;
    #1;
    chk1("rst_wait_level", db_level, 1'b0);
    chk1("rst_wait_rise", db_rise, 1'b0);
    tog_model = 1'b0;
    cycles(3);
    reset = 1'b0;
    push_ev(1'b1);
    cycles(14);
    chk1("after_rst_level", db_level, 1'b1);

    // Reset while HIGH clears outputs asynchronously
    #2 reset = 1'b1;
    #1;
    chk1("rst_high_level", db_level, 1'b0);
    chk1("rst_high_toggle", db_toggle, 1'b0);
    tog_model = 1'b0;
    btn_raw = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(12);
    chk1("idle_level", db_level, 1'b0);

    // Clean press: level rises exactly at edge 10
    btn_raw = 1'b1;
    push_ev(1'b1);
    cycles(10);
    chk1("press_edge9_level", db_level, 1'b0);
    cycles(1);
    chk1("press_edge10_level", db_level, 1'b1);
    cycles(1);
    chk1("press_rise_one_clock", db_rise, 1'b0);
    cycles(3);

    // Clean release: fall at edge 10
    btn_raw = 1'b0;
    push_ev(1'b0);
    cycles(10);
    chk1("release_edge9_level", db_level, 1'b1);
    cycles(1);
    chk1("release_edge10_level", db_level, 1'b0);
    cycles(4);

    // 5-clock glitch is rejected
    btn_raw = 1'b1;
    cycles(5);
    btn_raw = 1'b0;
    cycles(20);
    chk1("glitch_level", db_level, 1'b0);

    // Bounce then steady high: one rise, 10 clocks after the last 0->1
    btn_raw = 1'b1; cycles(2);
    btn_raw = 1'b0; cycles(2);
    btn_raw = 1'b1; cycles(2);
    btn_raw = 1'b0; cycles(2);
    btn_raw = 1'b1;
    push_ev(1'b1);
    cycles(14);
    chk1("bounce_level", db_level, 1'b1);

    // Three more presses exercise the toggle output
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b0;
      push_ev(1'b0);
      cycles(14);
      btn_raw = 1'b1;
      push_ev(1'b1);
      cycles(14);
      chk1("press_toggle", db_toggle, tog_model);
    end

    cycles(3);
    chki("pending_pulses", exp_q.size(), 0);
    chk1("final_level", db_level, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
